mult_pipe_sv: RTL and testbench

//   Parametrised, pipelined multiplier. Successor to the fixed 18x18 combinational signed multiplier.

---
 rtl/mult_pipe_sv.sv | 151 +++++++++++++++
 tb/tb_mult_pipe_sv.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/mult_pipe_sv.sv
// Pipelined WA x WB multiplier with per-operand signed/unsigned mode.
// Define MULT_PIPE_ACC_EN to turn the output register into an accumulator.
module mult_pipe_sv #(
  parameter int WA      = 18,
  parameter int WB      = 18,
  parameter int LATENCY = 3,
  parameter int GUARD   = 8,
`ifdef MULT_PIPE_ACC_EN
  localparam int PW     = WA + WB + GUARD
`else
  localparam int PW     = WA + WB
`endif
) (
  input  logic          C,
  input  logic          R,
  input  logic          CE,
  input  logic          IN_VALID,
  input  logic [WA-1:0] A,
  input  logic [WB-1:0] B,
  input  logic          A_SIGNED,
  input  logic          B_SIGNED,
`ifdef MULT_PIPE_ACC_EN
  input  logic          ACC_CLR,
`endif
  output logic          OUT_VALID,
  output logic [PW-1:0] P
);

  localparam int EA = WA + 1;
  localparam int EB = WB + 1;
  localparam int FW = EA + EB;
  localparam int D  = LATENCY - 1;

  if (LATENCY < 1) begin : g_bad_latency
    $error("mult_pipe_sv: LATENCY must be >= 1");
  end
  if (WA < 2 || WB < 2) begin : g_bad_width
    $error("mult_pipe_sv: WA and WB must be >= 2");
  end
  if (GUARD < 0) begin : g_bad_guard
    $error("mult_pipe_sv: GUARD must be >= 0");
  end

  logic signed [EA-1:0] in_a;
  logic signed [EB-1:0] in_b;
  logic signed [EA-1:0] la;
  logic signed [EB-1:0] lb;
  logic                 lv;
`ifdef MULT_PIPE_ACC_EN
  logic                 lc;
`endif

  // Mode bits are folded into the operands here, so they travel with them
  assign in_a = {A_SIGNED & A[WA-1], A};
  assign in_b = {B_SIGNED & B[WB-1], B};

  if (D > 0) begin : g_pipe
    logic                 v  [D];
    logic signed [EA-1:0] sa [D];
    logic signed [EB-1:0] sb [D];
`ifdef MULT_PIPE_ACC_EN
    logic                 c  [D];
`endif

    // Operand shift chain; data regs load only behind a valid bit
    always_ff @(posedge C) begin
      if (R) begin
        for (int i = 0; i < D; i++) begin
          v[i]  <= 1'b0;
          sa[i] <= '0;
          sb[i] <= '0;
`ifdef MULT_PIPE_ACC_EN
          c[i]  <= 1'b0;
`endif
        end
      end else if (CE) begin
        v[0] <= IN_VALID;
        if (IN_VALID) begin
          sa[0] <= in_a;
          sb[0] <= in_b;
`ifdef MULT_PIPE_ACC_EN
          c[0]  <= ACC_CLR;
`endif
        end
        for (int i = 1; i < D; i++) begin
          v[i] <= v[i-1];
          if (v[i-1]) begin
            sa[i] <= sa[i-1];
            sb[i] <= sb[i-1];
`ifdef MULT_PIPE_ACC_EN
            c[i]  <= c[i-1];
`endif
          end
        end
      end
    end

    assign lv = v[D-1];
    assign la = sa[D-1];
    assign lb = sb[D-1];
`ifdef MULT_PIPE_ACC_EN
    assign lc = c[D-1];
`endif
  end else begin : g_direct
    assign lv = IN_VALID;
    assign la = in_a;
    assign lb = in_b;
`ifdef MULT_PIPE_ACC_EN
    assign lc = ACC_CLR;
`endif
  end

`ifdef MULT_PIPE_ACC_EN
  logic [PW-1:0] addend;

  // Exact signed product, sign-extended (or truncated) to the accumulator
  assign addend = PW'(FW'(la) * FW'(lb));

  // Accumulator register doubles as the output register
  always_ff @(posedge C) begin
    if (R) begin
      OUT_VALID <= 1'b0;
      P         <= '0;
    end else if (CE) begin
      OUT_VALID <= lv;
      if (lv) begin
        P <= lc ? addend : P + addend;
      end
    end
  end
`else
  logic [PW-1:0] prod;

  // Low WA+WB bits of the extended signed product are exact
  assign prod = PW'(FW'(la) * FW'(lb));

  // Output register holds the last result between valid cycles
  always_ff @(posedge C) begin
    if (R) begin
      OUT_VALID <= 1'b0;
      P         <= '0;
    end else if (CE) begin
      OUT_VALID <= lv;
      if (lv) begin
        P <= prod;
      end
    end
  end
`endif

endmodule

// File: tb/tb_mult_pipe_sv.sv
// Self-checking bench for mult_pipe_sv at LATENCY=3 and LATENCY=1.
// Accumulator checks are built when MULT_PIPE_ACC_EN is defined.
module tb_mult_pipe_sv;

  localparam int MW = 36;
`ifdef MULT_PIPE_ACC_EN
  localparam int PW = MW + 8;
`else
  localparam int PW = MW;
`endif

  logic          C = 1'b0;
  logic          R, CE, iv, as_, bs_, clr;
  logic [17:0]   a, b;
  logic          ov3, ov1;
  logic [PW-1:0] p3, p1;
  int            errors = 0;
  int            checks = 0;

  always #5 C = ~C;

  mult_pipe_sv #(.WA(18), .WB(18), .LATENCY(3), .GUARD(8)) dut3 (
    .C(C), .R(R), .CE(CE), .IN_VALID(iv), .A(a), .B(b),
    .A_SIGNED(as_), .B_SIGNED(bs_),
`ifdef MULT_PIPE_ACC_EN
    .ACC_CLR(clr),
`endif
    .OUT_VALID(ov3), .P(p3)
  );

  mult_pipe_sv #(.WA(18), .WB(18), .LATENCY(1), .GUARD(8)) dut1 (
    .C(C), .R(R), .CE(CE), .IN_VALID(iv), .A(a), .B(b),
    .A_SIGNED(as_), .B_SIGNED(bs_),
`ifdef MULT_PIPE_ACC_EN
    .ACC_CLR(clr),
`endif
    .OUT_VALID(ov1), .P(p1)
  );

  // Reference model: history of enabled-edge samples, output = sample
  // taken LATENCY-1 enabled edges earlier
  typedef struct {
    bit          v;
    bit          clr;
    logic [63:0] prod;
  } hist_t;

  hist_t         hist[$];
  bit            mv[2];
  logic [PW-1:0] mp[2];
  int            lat[2] = '{3, 1};

  function automatic logic [63:0] exact(logic [17:0] x, logic [17:0] y,
                                        bit xs, bit ys);
    longint xv, yv;
    xv = longint'(x);
    yv = longint'(y);
    if (xs && x[17]) xv = xv - 262144;
    if (ys && y[17]) yv = yv - 262144;
    return xv * yv;
  endfunction

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic model_edge();
    hist_t e;
    if (R) begin
      hist.delete();
      mv = '{0, 0};
      mp = '{'0, '0};
    end else if (CE) begin
      e.v    = iv;
      e.clr  = clr;
      e.prod = exact(a, b, as_, bs_);
      hist.push_back(e);
      for (int k = 0; k < 2; k++) begin
        int idx = hist.size() - lat[k];
        mv[k] = 0;
        if (idx >= 0 && hist[idx].v) begin
          mv[k] = 1;
`ifdef MULT_PIPE_ACC_EN
          if (hist[idx].clr) mp[k] = hist[idx].prod[PW-1:0];
          else mp[k] = mp[k] + hist[idx].prod[PW-1:0];
`else
          mp[k] = hist[idx].prod[PW-1:0];
`endif
        end
      end
      while (hist.size() > 8) void'(hist.pop_front());
    end
  endtask

  task automatic step(bit v, logic [17:0] x, logic [17:0] y, bit xs, bit ys,
                      bit c, bit ce, bit r);
    iv = v; a = x; b = y; as_ = xs; bs_ = ys; clr = c; CE = ce; R = r;
    @(posedge C);
    model_edge();
    #1;
    chk("model_ov_lat3", ov3, mv[0]);
    chk("model_p_lat3", p3, mp[0]);
    chk("model_ov_lat1", ov1, mv[1]);
    chk("model_p_lat1", p1, mp[1]);
  endtask

  task automatic bubble();
    step(0, 0, 0, 0, 0, 0, 1, 0);
  endtask

  typedef struct {
    logic [17:0] a;
    logic [17:0] b;
    bit          as;
    bit          bs;
    logic [35:0] exp;
  } vec_t;

  vec_t tbl[7];

  logic [17:0] corner[5] = '{18'h00000, 18'h00001, 18'h20000,
                             18'h1FFFF, 18'h3FFFF};

  initial begin
    tbl[0] = '{18'h3FFFF, 18'h00002, 1, 1, 36'hFFFFFFFFE};
    tbl[1] = '{18'h3FFFF, 18'h00002, 0, 0, 36'h00007FFFE};
    tbl[2] = '{18'h20000, 18'h3FFFF, 1, 0, 36'h800020000};
    tbl[3] = '{18'h3FFFF, 18'h3FFFF, 0, 0, 36'hFFFF80001};
    tbl[4] = '{18'h20000, 18'h20000, 1, 1, 36'h400000000};
    tbl[5] = '{18'h3FFFF, 18'h3FFFF, 1, 1, 36'h000000001};
    tbl[6] = '{18'h1FFFF, 18'h20000, 0, 1, 36'hC00020000};

    // Reset held two edges with valid input present
    for (int i = 0; i < 2; i++) begin
      step(1, 5, 5, 0, 0, 1, 1, 1);
      chk("rst_ov", ov3, 0);
      chk("rst_p", p3, 0);
    end
    for (int i = 0; i < 4; i++) begin
      bubble();
      chk("post_rst_ov", ov3, 0);
      chk("post_rst_p", p3, 0);
    end

    // Table of single operations
    foreach (tbl[i]) begin
      step(1, tbl[i].a, tbl[i].b, tbl[i].as, tbl[i].bs, 1, 1, 0);
      chk("tbl_lat1_ov", ov1, 1);
      chk("tbl_lat1_p", p1[35:0], tbl[i].exp);
      bubble();
      chk("tbl_early_ov", ov3, 0);
      bubble();
      chk("tbl_ov", ov3, 1);
      chk("tbl_p", p3[35:0], tbl[i].exp);
      bubble();
      chk("tbl_ov_drop", ov3, 0);
      chk("tbl_p_hold", p3[35:0], tbl[i].exp);
    end

    // Stall for two cycles after the second of three inputs
    step(1, 1, 1, 0, 0, 1, 1, 0);
    chk("stall_ov1", ov3, 0);
    step(1, 2, 3, 0, 0, 1, 1, 0);
    chk("stall_ov2", ov3, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0);
    chk("stall_ov3", ov3, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0);
    chk("stall_ov4", ov3, 0);
    step(1, 4, 5, 0, 0, 1, 1, 0);
    chk("stall_out1_ov", ov3, 1);
    chk("stall_out1_p", p3[35:0], 1);
    bubble();
    chk("stall_out2_ov", ov3, 1);
    chk("stall_out2_p", p3[35:0], 6);
    bubble();
    chk("stall_out3_ov", ov3, 1);
    chk("stall_out3_p", p3[35:0], 20);
    bubble();
    chk("stall_end_ov", ov3, 0);

    // LATENCY=1 emits on the sampling edge
    step(1, 7, 9, 0, 0, 1, 1, 0);
    chk("lat1_ov", ov1, 1);
    chk("lat1_p", p1, 63);
    bubble();
    chk("lat1_drop", ov1, 0);

    // Reset with two operations in flight
    step(1, 11, 13, 0, 0, 1, 1, 0);
    step(1, 17, 19, 0, 0, 1, 1, 0);
    step(0, 0, 0, 0, 0, 0, 1, 1);
    chk("flight_rst_p", p3, 0);
    for (int i = 0; i < 4; i++) begin
      bubble();
      chk("flight_ov", ov3, 0);
      chk("flight_p", p3, 0);
    end

`ifdef MULT_PIPE_ACC_EN
    // Accumulate 35, +12, -1; bubbles and ignored clear hold the sum
    step(1, 5, 7, 1, 1, 1, 1, 0);
    step(1, 3, 4, 1, 1, 0, 1, 0);
    step(1, 18'h3FFFF, 1, 1, 1, 0, 1, 0);
    chk("acc_ov1", ov3, 1);
    chk("acc_p1", p3, 35);
    bubble();
    chk("acc_p2", p3, 47);
    bubble();
    chk("acc_p3", p3, 46);
    bubble();
    chk("acc_bubble_ov", ov3, 0);
    chk("acc_bubble_p", p3, 46);
    step(0, 9, 9, 0, 0, 1, 1, 0);
    bubble();
    bubble();
    chk("acc_clr_ignored", p3, 46);
`endif

    // Randomized traffic against the model
    for (int i = 0; i < 600; i++) begin
      logic [17:0] x, y;
      x = ($urandom % 4 == 0) ? corner[$urandom % 5] : 18'($urandom);
      y = ($urandom % 4 == 0) ? corner[$urandom % 5] : 18'($urandom);
      step(bit'($urandom % 4 != 0), x, y, bit'($urandom % 2),
           bit'($urandom % 2), bit'($urandom % 4 == 0),
           bit'($urandom % 8 != 0), bit'($urandom % 64 == 0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
